// File: rtl/down_counter_timer.sv
// ----------------------------------------------------------------------------
// down_counter_timer
//   Loadable down counter with terminal-count detection, for use as a
//   programmable tick / timeout generator. It supports one-shot and periodic
//   (auto-reload) operation under a three-state control FSM
//   (IDLE / RUN / DONE). Every output comes straight from a flop.
//
// Parameters
//   WIDTH     counter and reload register width in bits (2..16)
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous, active-low reset
//   load      capture load_val into the reload register and the counter
//   load_val  reload value
//   start     (re)start counting from the reload value
//   stop      halt counting and hold the count
//   periodic  1 = auto-reload on terminal count, 0 = one-shot
//   en        count-enable tick; one decrement per enabled RUN cycle
//   count     current counter value
//   tc        terminal-count pulse, one cycle wide
//   busy      high while the FSM is in RUN
//   done      sticky one-shot completion flag
// ----------------------------------------------------------------------------
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             done_d;

  // Decrement that floors at zero so the count can never wrap.
  function automatic logic [WIDTH-1:0] dec_floor(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WIDTH'(1);
  endfunction

  // Next-state logic; priority is load > stop > start > en.
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    count_d  = count;
    done_d   = done;
    tc_d     = 1'b0;

    if (load) begin
      reload_d = load_val;
      count_d  = load_val;
      state_d  = IDLE;
      done_d   = 1'b0;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = IDLE;
      end
    end else if (start) begin
      // A zero reload value would give a zero-length period; ignore start.
      if (reload_q != '0) begin
        count_d = reload_q;
        state_d = RUN;
        done_d  = 1'b0;
      end
    end else if (state_q == RUN && en) begin
      if (count == WIDTH'(1)) begin
        tc_d = 1'b1;
        if (periodic) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end else begin
        count_d = dec_floor(count);
      end
    end
  end

  // State and output registers; busy is registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      reload_q <= '0;
      count    <= '0;
      tc       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      count    <= count_d;
      tc       <= tc_d;
      busy     <= (state_d == RUN);
      done     <= done_d;
    end
  end

endmodule
